duty_button_ctrl: RTL and testbench

- Upstream stage of the duty record/playback RAM: turns the four raw push buttons into debounced, auto-repeating step commands.
- Maintains the live X/Y duty values, which feed the RAM's Duty_X/Duty_Y inputs.
- Emits one-cycle step strobes so the RAM's storage address advances exactly once per accepted step, never every clock while a button is held.

---
 rtl/duty_button_ctrl_pkg.sv | 44 ++++
 rtl/duty_button_ctrl_button_debounce.sv | 93 +++++++++
 rtl/duty_button_ctrl.sv | 81 ++++++++
 tb/tb_duty_button_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_button_ctrl_pkg.sv
// Shared constants, repeat FSM state type and the saturating axis update
// used by the duty button controller.
package duty_button_ctrl_pkg;

    localparam int DUTY_W  = 6;
    localparam int NUM_BTN = 4;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // One extra bit of headroom so neither 63+1 nor 0-1 can wrap.
    function automatic logic [DUTY_W-1:0] axis_next(
        input logic [DUTY_W-1:0] cur,
        input logic              inc,
        input logic              dec,
        input logic [DUTY_W-1:0] max_val
    );
        logic [DUTY_W:0] wide;
        logic [DUTY_W:0] one;
        one  = {{DUTY_W{1'b0}}, 1'b1};
        wide = {1'b0, cur};
        if (inc && !dec) begin
            wide = wide + one;
            if (wide > {1'b0, max_val}) begin
                wide = {1'b0, max_val};
            end
        end else if (dec && !inc) begin
            wide = wide - one;
            if (wide[DUTY_W]) begin
                wide = '0;
            end
        end
        return wide[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/duty_button_ctrl_button_debounce.sv
// One push button: 2-FF synchronizer, debounce counter and auto-repeat FSM
// producing a registered one-cycle step pulse.
module button_debounce
    import duty_button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic step
);

    localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TM_W      = $clog2(TIMER_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
    localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE - 1);
    localparam logic [TM_W-1:0] TM_ONE     = TM_W'(1);

    logic            sync_a;
    logic            sync_b;
    logic            level;
    logic [DB_W-1:0] db_cnt;
    logic [TM_W-1:0] timer;
    rpt_state_t      state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
            timer  <= '0;
            state  <= IDLE;
            step   <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;

            // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
            if (sync_b == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= sync_b;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end

            step <= 1'b0;
            if (!level) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        step  <= 1'b1;
                        state <= DELAY;
                        timer <= '0;
                    end
                    DELAY: begin
                        if (timer == DELAY_LAST) begin
                            step  <= 1'b1;
                            state <= REPEAT;
                            timer <= '0;
                        end else begin
                            timer <= timer + TM_ONE;
                        end
                    end
                    REPEAT: begin
                        if (timer == RATE_LAST) begin
                            step  <= 1'b1;
                            timer <= '0;
                        end else begin
                            timer <= timer + TM_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/duty_button_ctrl.sv
// Four debounced auto-repeat buttons driving saturating X/Y duty registers
// and one-cycle step strobes for the record/playback RAM.
module duty_button_ctrl
    import duty_button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int DUTY_INIT       = 32,
    parameter int DUTY_MAX        = 63
) (
    input  logic              sysclk,
    input  logic              Reset_n,
    input  logic              Bt_Up,
    input  logic              Bt_Down,
    input  logic              Bt_Left,
    input  logic              Bt_Right,
    output logic [DUTY_W-1:0] Duty_X,
    output logic [DUTY_W-1:0] Duty_Y,
    output logic              Step_Up,
    output logic              Step_Down,
    output logic              Step_Left,
    output logic              Step_Right,
    output logic              Any_Step
);

    localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);
    localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] step;
    logic               up_ok;
    logic               down_ok;
    logic               left_ok;
    logic               right_ok;

    assign raw[UP]    = Bt_Up;
    assign raw[DOWN]  = Bt_Down;
    assign raw[LEFT]  = Bt_Left;
    assign raw[RIGHT] = Bt_Right;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_btn (
            .clk  (sysclk),
            .rst_n(Reset_n),
            .raw  (raw[i]),
            .step (step[i])
        );
    end

    // Opposite steps on one axis cancel: no strobe and no duty change.
    assign up_ok    = step[UP]    & ~step[DOWN];
    assign down_ok  = step[DOWN]  & ~step[UP];
    assign right_ok = step[RIGHT] & ~step[LEFT];
    assign left_ok  = step[LEFT]  & ~step[RIGHT];

    always_ff @(posedge sysclk) begin
        if (!Reset_n) begin
            Duty_X     <= INIT_V;
            Duty_Y     <= INIT_V;
            Step_Up    <= 1'b0;
            Step_Down  <= 1'b0;
            Step_Left  <= 1'b0;
            Step_Right <= 1'b0;
            Any_Step   <= 1'b0;
        end else begin
            Duty_X     <= axis_next(Duty_X, right_ok, left_ok, MAX_V);
            Duty_Y     <= axis_next(Duty_Y, up_ok, down_ok, MAX_V);
            Step_Up    <= up_ok;
            Step_Down  <= down_ok;
            Step_Left  <= left_ok;
            Step_Right <= right_ok;
            Any_Step   <= up_ok | down_ok | left_ok | right_ok;
        end
    end

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Scoreboard bench for duty_button_ctrl with short debounce/repeat timing;
// expected step cycles are queued when a button hold is driven.
module tb_duty_button_ctrl;
    import duty_button_ctrl_pkg::*;

    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RR   = 3;
    localparam int INIT = 32;
    localparam int MAXV = 63;

    logic       sysclk = 1'b0;
    logic       Reset_n;
    logic       Bt_Up, Bt_Down, Bt_Left, Bt_Right;
    logic [5:0] Duty_X, Duty_Y;
    logic       Step_Up, Step_Down, Step_Left, Step_Right, Any_Step;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_x, exp_y;
    logic [31:0] exp_q[$];   // {visible cycle[27:0], effective step mask[3:0]}
    logic [3:0]  exp_v;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    duty_button_ctrl #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
        .DUTY_INIT(INIT), .DUTY_MAX(MAXV)
    ) dut (
        .sysclk(sysclk), .Reset_n(Reset_n),
        .Bt_Up(Bt_Up), .Bt_Down(Bt_Down), .Bt_Left(Bt_Left), .Bt_Right(Bt_Right),
        .Duty_X(Duty_X), .Duty_Y(Duty_Y),
        .Step_Up(Step_Up), .Step_Down(Step_Down), .Step_Left(Step_Left),
        .Step_Right(Step_Right), .Any_Step(Any_Step)
    );

    task automatic set_btn(input logic [3:0] m, input logic v);
        if (m[UP])    Bt_Up    = v;
        if (m[DOWN])  Bt_Down  = v;
        if (m[LEFT])  Bt_Left  = v;
        if (m[RIGHT]) Bt_Right = v;
    endtask

    // Called at a negedge: the next posedge is the first sampling edge s.
    // Steps leave the FSM at s+DB+2, then +RD, then every RR, while the
    // debounced level (high until edge s+h+DB+1) still holds.
    task automatic drive_hold(input logic [3:0] m, input int h);
        int c, e, v;
        bit first;
        logic [3:0] eff;
        c = cyc;
        set_btn(m, 1'b1);
        eff = m;
        if (m[UP] && m[DOWN]) begin eff[UP] = 1'b0; eff[DOWN] = 1'b0; end
        if (m[LEFT] && m[RIGHT]) begin eff[LEFT] = 1'b0; eff[RIGHT] = 1'b0; end
        if (h >= DB) begin
            e = c + 1 + DB + 2;
            first = 1'b1;
            while (e <= c + 1 + h + DB + 1) begin
                v = e + 1;
                exp_q.push_back({v[27:0], eff});
                e = e + (first ? RD : RR);
                first = 1'b0;
            end
        end
        repeat (h) @(negedge sysclk);
        set_btn(m, 1'b0);
    endtask

    function automatic void model_apply(input logic [3:0] m);
        if (m[UP])    exp_y = (exp_y < MAXV) ? exp_y + 1 : MAXV;
        if (m[DOWN])  exp_y = (exp_y > 0) ? exp_y - 1 : 0;
        if (m[RIGHT]) exp_x = (exp_x < MAXV) ? exp_x + 1 : MAXV;
        if (m[LEFT])  exp_x = (exp_x > 0) ? exp_x - 1 : 0;
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge sysclk);
        n_cmp++;
        if (Duty_X !== 6'd32 || Duty_Y !== 6'd32 || Any_Step !== 1'b0 ||
            {Step_Right, Step_Left, Step_Down, Step_Up} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_values: X=%0d Y=%0d steps=%b any=%b, want 32 32 0000 0",
                     Duty_X, Duty_Y, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step);
        end
        Reset_n = 1'b1;
        repeat (50) begin
            @(negedge sysclk);
            n_cmp++;
            if (Duty_X !== 6'd32 || Duty_Y !== 6'd32 || Any_Step !== 1'b0 ||
                {Step_Right, Step_Left, Step_Down, Step_Up} !== 4'b0) begin
                n_err++;
                $display("FAIL idle_after_reset cyc=%0d: X=%0d Y=%0d steps=%b any=%b, want 32 32 0000 0",
                         cyc, Duty_X, Duty_Y, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step);
            end
        end
    endtask

    // Each scenario below runs the same per-cycle scoreboard comparison.
    task automatic test_glitch;
        @(negedge sysclk);
        fork drive_hold(4'b0001, 3); join_none
        repeat (20) begin
            @(negedge sysclk);
            exp_v = 4'b0;
            if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) begin
                exp_v = exp_q[0][3:0]; void'(exp_q.pop_front()); model_apply(exp_v);
            end
            n_cmp++;
            if ({Step_Right, Step_Left, Step_Down, Step_Up} !== exp_v || Any_Step !== |exp_v ||
                Duty_X !== exp_x[5:0] || Duty_Y !== exp_y[5:0]) begin
                n_err++;
                $display("FAIL glitch cyc=%0d: steps=%b any=%b X=%0d Y=%0d, want %b %b %0d %0d",
                         cyc, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step, Duty_X, Duty_Y,
                         exp_v, |exp_v, exp_x, exp_y);
            end
        end
    endtask

    task automatic test_single_press;
        @(negedge sysclk);
        fork drive_hold(4'b0001, 8); join_none
        repeat (30) begin
            @(negedge sysclk);
            exp_v = 4'b0;
            if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) begin
                exp_v = exp_q[0][3:0]; void'(exp_q.pop_front()); model_apply(exp_v);
            end
            n_cmp++;
            if ({Step_Right, Step_Left, Step_Down, Step_Up} !== exp_v || Any_Step !== |exp_v ||
                Duty_X !== exp_x[5:0] || Duty_Y !== exp_y[5:0]) begin
                n_err++;
                $display("FAIL single_press cyc=%0d: steps=%b any=%b X=%0d Y=%0d, want %b %b %0d %0d",
                         cyc, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step, Duty_X, Duty_Y,
                         exp_v, |exp_v, exp_x, exp_y);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || Duty_Y !== 6'd33) begin
            n_err++;
            $display("FAIL single_press_end: pending=%0d Y=%0d, want 0 33", exp_q.size(), Duty_Y);
        end
    endtask

    task automatic test_auto_repeat;
        @(negedge sysclk);
        fork drive_hold(4'b1000, 40); join_none
        repeat (60) begin
            @(negedge sysclk);
            exp_v = 4'b0;
            if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) begin
                exp_v = exp_q[0][3:0]; void'(exp_q.pop_front()); model_apply(exp_v);
            end
            n_cmp++;
            if ({Step_Right, Step_Left, Step_Down, Step_Up} !== exp_v || Any_Step !== |exp_v ||
                Duty_X !== exp_x[5:0] || Duty_Y !== exp_y[5:0]) begin
                n_err++;
                $display("FAIL auto_repeat cyc=%0d: steps=%b any=%b X=%0d Y=%0d, want %b %b %0d %0d",
                         cyc, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step, Duty_X, Duty_Y,
                         exp_v, |exp_v, exp_x, exp_y);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || Duty_X !== 6'd43) begin
            n_err++;
            $display("FAIL auto_repeat_end: pending=%0d X=%0d, want 0 43", exp_q.size(), Duty_X);
        end
    endtask

    task automatic test_saturation;
        @(negedge sysclk);
        fork drive_hold(4'b0010, 150); join_none
        repeat (170) begin
            @(negedge sysclk);
            exp_v = 4'b0;
            if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) begin
                exp_v = exp_q[0][3:0]; void'(exp_q.pop_front()); model_apply(exp_v);
            end
            n_cmp++;
            if ({Step_Right, Step_Left, Step_Down, Step_Up} !== exp_v || Any_Step !== |exp_v ||
                Duty_X !== exp_x[5:0] || Duty_Y !== exp_y[5:0]) begin
                n_err++;
                $display("FAIL saturation cyc=%0d: steps=%b any=%b X=%0d Y=%0d, want %b %b %0d %0d",
                         cyc, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step, Duty_X, Duty_Y,
                         exp_v, |exp_v, exp_x, exp_y);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || Duty_Y !== 6'd0) begin
            n_err++;
            $display("FAIL saturation_end: pending=%0d Y=%0d, want 0 0", exp_q.size(), Duty_Y);
        end
    endtask

    task automatic test_cancel;
        @(negedge sysclk);
        fork drive_hold(4'b1100, 30); join_none
        repeat (45) begin
            @(negedge sysclk);
            exp_v = 4'b0;
            if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) begin
                exp_v = exp_q[0][3:0]; void'(exp_q.pop_front()); model_apply(exp_v);
            end
            n_cmp++;
            if ({Step_Right, Step_Left, Step_Down, Step_Up} !== exp_v || Any_Step !== |exp_v ||
                Duty_X !== exp_x[5:0] || Duty_Y !== exp_y[5:0]) begin
                n_err++;
                $display("FAIL cancel cyc=%0d: steps=%b any=%b X=%0d Y=%0d, want %b %b %0d %0d",
                         cyc, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step, Duty_X, Duty_Y,
                         exp_v, |exp_v, exp_x, exp_y);
            end
        end
    endtask

    task automatic test_both_axes;
        @(negedge sysclk);
        fork drive_hold(4'b1001, 6); join_none
        repeat (25) begin
            @(negedge sysclk);
            exp_v = 4'b0;
            if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) begin
                exp_v = exp_q[0][3:0]; void'(exp_q.pop_front()); model_apply(exp_v);
            end
            n_cmp++;
            if ({Step_Right, Step_Left, Step_Down, Step_Up} !== exp_v || Any_Step !== |exp_v ||
                Duty_X !== exp_x[5:0] || Duty_Y !== exp_y[5:0]) begin
                n_err++;
                $display("FAIL both_axes cyc=%0d: steps=%b any=%b X=%0d Y=%0d, want %b %b %0d %0d",
                         cyc, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step, Duty_X, Duty_Y,
                         exp_v, |exp_v, exp_x, exp_y);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || Duty_X !== 6'd44 || Duty_Y !== 6'd1) begin
            n_err++;
            $display("FAIL both_axes_end: pending=%0d X=%0d Y=%0d, want 0 44 1", exp_q.size(), Duty_X, Duty_Y);
        end
    endtask

    task automatic test_reset_mid_repeat;
        @(negedge sysclk);
        Bt_Up = 1'b1;
        repeat (25) @(negedge sysclk);
        Reset_n = 1'b0;
        exp_q.delete();
        exp_x = INIT;
        exp_y = INIT;
        repeat (3) begin
            @(negedge sysclk);
            n_cmp++;
            if (Duty_X !== 6'd32 || Duty_Y !== 6'd32 || Any_Step !== 1'b0 || Step_Up !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset cyc=%0d: X=%0d Y=%0d up=%b any=%b, want 32 32 0 0",
                         cyc, Duty_X, Duty_Y, Step_Up, Any_Step);
            end
        end
        Reset_n = 1'b1;
        fork drive_hold(4'b0001, 12); join_none
        repeat (30) begin
            @(negedge sysclk);
            exp_v = 4'b0;
            if (exp_q.size() > 0 && exp_q[0][31:4] == cyc[27:0]) begin
                exp_v = exp_q[0][3:0]; void'(exp_q.pop_front()); model_apply(exp_v);
            end
            n_cmp++;
            if ({Step_Right, Step_Left, Step_Down, Step_Up} !== exp_v || Any_Step !== |exp_v ||
                Duty_X !== exp_x[5:0] || Duty_Y !== exp_y[5:0]) begin
                n_err++;
                $display("FAIL reset_requalify cyc=%0d: steps=%b any=%b X=%0d Y=%0d, want %b %b %0d %0d",
                         cyc, {Step_Right, Step_Left, Step_Down, Step_Up}, Any_Step, Duty_X, Duty_Y,
                         exp_v, |exp_v, exp_x, exp_y);
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || Duty_Y !== 6'd34) begin
            n_err++;
            $display("FAIL reset_requalify_end: pending=%0d Y=%0d, want 0 34", exp_q.size(), Duty_Y);
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        Bt_Up    = 1'b0;
        Bt_Down  = 1'b0;
        Bt_Left  = 1'b0;
        Bt_Right = 1'b0;
        exp_x    = INIT;
        exp_y    = INIT;
        test_reset;
        test_glitch;
        test_single_press;
        test_auto_repeat;
        test_saturation;
        test_cancel;
        test_both_axes;
        test_reset_mid_repeat;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
